instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
- Fetch-to-decode instruction buffer. It sits directly upstream of the decode stage, whose opcode/funct pattern matchers consume the queue head combinationally.
- It decouples fetch from decode with a DEPTH-entry circular FIFO of {instruction, PC} pairs, using valid/ready handshakes on both sides.
- A flush input drops all in-flight entries on branch redirect or exception.

Parameters:
- XLEN, 64, PC width in bits.
- ILEN, 32, instruction width in bits.
- DEPTH, 4, number of entries; legal range 2..16, not required to be a power of two.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- arst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous flush; discards all stored entries.
- in_instr_i  input  ILEN  instruction word from fetch.
- in_pc_i  input  XLEN  PC of in_instr_i.
- in_valid_i  input  1  fetch presents a valid entry.
- in_ready_o  output  1  queue can accept an entry this cycle.
- out_instr_o  output  ILEN  head instruction, to the decode matchers.
- out_pc_o  output  XLEN  head PC.
- out_valid_o  output  1  head entry is valid.
- out_ready_i  input  1  decode consumes the head this cycle.
- count_o  output  $clog2(DEPTH+1)  number of stored entries.

Behaviour:
- State:
  - mem[DEPTH] of {ILEN+XLEN} bits.
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0. Increment is not modulo 2^n unless DEPTH is a power of two.
  - count register, 0..DEPTH.
- Reset (arst_ni low, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Hence out_valid_o=0, in_ready_o=1, count_o=0, out_instr_o=0, out_pc_o=0.
  - mem contents are not reset.
- Flags:
  - in_ready_o = (count != DEPTH). Purely registered-state derived; no combinational path from out_ready_i.
  - out_valid_o = (count != 0).
- Transfers:
  - push = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i.
- Push:
  - mem[wr_ptr] <= {in_instr_i, in_pc_i}.
  - wr_ptr advances.
- Pop:
  - rd_ptr advances.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Outputs:
  - out_instr_o/out_pc_o = mem[rd_ptr] when count != 0, else all zeros. This is combinational from registers, so zero-latency to decode.
- Latency:
  - An entry pushed in cycle N is visible at the output in cycle N+1.
  - There is no fall-through bypass in cycle N, even when empty.
- Full:
  - in_ready_o=0.
  - A simultaneous pop in the same cycle does not permit a push; in_ready_o rises the cycle after the pop.
- Empty:
  - out_valid_o=0.
  - out_ready_i is ignored and no pointer moves.
- Flush (highest priority, synchronous):
  - On the edge where flush_i=1: wr_ptr=0, rd_ptr=0, count=0.
  - Any push or pop in that cycle is discarded (no write to mem required).
  - out_valid_o may still be 1 during the flush cycle. Decode must qualify with its own flush, and the queue does not gate out_valid_o by flush_i.
- Wrap-around:
  - Order is strictly FIFO across pointer wrap for any DEPTH in range, including non-power-of-two values.
- Reset mid-operation:
  - Asserting arst_ni at any phase returns all outputs to the reset values immediately, without waiting for a clock edge.
  - The first push after deassertion lands at mem[0].
- Input stability:
  - The queue does not require in_instr_i/in_pc_i to be held while in_ready_o=0.
  - Fetch holds them per the handshake rule: valid is not dropped without a transfer, except on flush.

Test Plan:
- Reset then idle → out_valid_o=0, in_ready_o=1, count_o=0, out_instr_o=0, out_pc_o=0.
- Push instr 0x00000013 at PC 0x80000000 with out_ready_i=0 → next cycle out_valid_o=1, out_instr_o=0x00000013, out_pc_o=0x80000000, count_o=1.
- Fill DEPTH=4 with PCs 0x0,0x4,0x8,0xC, then hold in_valid_i=1 with PC 0x10 → in_ready_o=0 and count_o=4. Pop one → in_ready_o=1 next cycle; 0x10 accepted; pops return 0x4,0x8,0xC,0x10 in order.
- Push and pop together on each of 10 cycles with count=2 → count_o stays 2, pointers wrap correctly, output order matches input order.
- Flush with count=3 while in_valid_i=1 → next cycle count_o=0, out_valid_o=0, and the pushed entry is absent. Re-run with DEPTH=3 through 7 wraps → no loss or duplication.
- Assert arst_ni mid-stream with count=2 → out_valid_o=0 within the same cycle. After release, push PC 0x100 → it is the first popped entry.

Source files
------------

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction buffer: DEPTH-entry circular FIFO of {instruction, PC} pairs
// with valid/ready handshakes on both sides and a synchronous flush for redirects.
module instr_queue #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic                       flush_i,

    input  logic [ILEN-1:0]            in_instr_i,
    input  logic [XLEN-1:0]            in_pc_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,

    output logic [ILEN-1:0]            out_instr_o,
    output logic [XLEN-1:0]            out_pc_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,

    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned EntW = ILEN + XLEN;

    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [EntW-1:0] mem_q [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic            push;
    logic            pop;
    logic [EntW-1:0] head;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
    endfunction

    // Flags depend only on the count register, so in_ready_o has no path from out_ready_i.
    assign in_ready_o  = (count_q != FullCnt);
    assign out_valid_o = (count_q != '0);

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; the count gates everything that leaves the queue.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= {in_instr_i, in_pc_i};
        end
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        out_instr_o = '0;
        out_pc_o    = '0;
        if (out_valid_o) begin
            {out_instr_o, out_pc_o} = head;
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: a vector table for the basic handshakes plus hand-written
// sequences for streaming, flush, asynchronous reset and a DEPTH=3 wrap run against a queue model.
module tb_instr_queue;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    logic            flush, in_valid, in_ready, out_valid, out_ready;
    logic [ILEN-1:0] in_instr, out_instr;
    logic [XLEN-1:0] in_pc, out_pc;
    logic [2:0]      count;

    logic            f3, v3, rdy3, ov3, or3;
    logic [ILEN-1:0] i3, oi3;
    logic [XLEN-1:0] p3, op3;
    logic [1:0]      cnt3;

    instr_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) u_dut (
        .clk_i       (clk),
        .arst_ni     (arst_n),
        .flush_i     (flush),
        .in_instr_i  (in_instr),
        .in_pc_i     (in_pc),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_instr_o (out_instr),
        .out_pc_o    (out_pc),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .count_o     (count)
    );

    instr_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(3)) u_dut3 (
        .clk_i       (clk),
        .arst_ni     (arst_n),
        .flush_i     (f3),
        .in_instr_i  (i3),
        .in_pc_i     (p3),
        .in_valid_i  (v3),
        .in_ready_o  (rdy3),
        .out_instr_o (oi3),
        .out_pc_o    (op3),
        .out_valid_o (ov3),
        .out_ready_i (or3),
        .count_o     (cnt3)
    );

    typedef struct {
        logic            flush;
        logic            in_valid;
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            out_ready;
        logic            exp_valid;
        logic            exp_ready;
        logic [2:0]      exp_count;
        logic [ILEN-1:0] exp_instr;
        logic [XLEN-1:0] exp_pc;
    } vec_t;

    vec_t vecs[14];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic ev, input logic er,
                             input logic [2:0] ec, input logic [ILEN-1:0] ei,
                             input logic [XLEN-1:0] ep);
        chk({tag, " out_valid"}, 64'(out_valid), 64'(ev));
        chk({tag, " in_ready"},  64'(in_ready),  64'(er));
        chk({tag, " count"},     64'(count),     64'(ec));
        chk({tag, " out_instr"}, 64'(out_instr), 64'(ei));
        chk({tag, " out_pc"},    64'(out_pc),    ep);
    endtask

    task automatic drive(input logic f, input logic v, input logic [ILEN-1:0] ins,
                         input logic [XLEN-1:0] pc, input logic r);
        flush     = f;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = r;
    endtask

    logic [ILEN+XLEN-1:0] q[$];
    logic [ILEN+XLEN-1:0] m3[$];

    initial begin
        // Expected state is sampled 1 time unit after the edge that follows each vector.
        vecs[0]  = '{1'b0, 1'b1, 32'h13, 64'h8000_0000, 1'b0, 1'b1, 1'b1, 3'd1, 32'h13, 64'h8000_0000};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,  64'h0,  1'b1, 1'b0, 1'b1, 3'd0, 32'h0,  64'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,  64'h0,  1'b1, 1'b0, 1'b1, 3'd0, 32'h0,  64'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'hA0, 64'h0,  1'b0, 1'b1, 1'b1, 3'd1, 32'hA0, 64'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'hA4, 64'h4,  1'b0, 1'b1, 1'b1, 3'd2, 32'hA0, 64'h0};
        vecs[5]  = '{1'b0, 1'b1, 32'hA8, 64'h8,  1'b0, 1'b1, 1'b1, 3'd3, 32'hA0, 64'h0};
        vecs[6]  = '{1'b0, 1'b1, 32'hAC, 64'hC,  1'b0, 1'b1, 1'b0, 3'd4, 32'hA0, 64'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'hB0, 64'h10, 1'b0, 1'b1, 1'b0, 3'd4, 32'hA0, 64'h0};
        vecs[8]  = '{1'b0, 1'b1, 32'hB0, 64'h10, 1'b1, 1'b1, 1'b1, 3'd3, 32'hA4, 64'h4};
        vecs[9]  = '{1'b0, 1'b1, 32'hB0, 64'h10, 1'b0, 1'b1, 1'b0, 3'd4, 32'hA4, 64'h4};
        vecs[10] = '{1'b0, 1'b0, 32'h0,  64'h0,  1'b1, 1'b1, 1'b1, 3'd3, 32'hA8, 64'h8};
        vecs[11] = '{1'b0, 1'b0, 32'h0,  64'h0,  1'b1, 1'b1, 1'b1, 3'd2, 32'hAC, 64'hC};
        vecs[12] = '{1'b0, 1'b0, 32'h0,  64'h0,  1'b1, 1'b1, 1'b1, 3'd1, 32'hB0, 64'h10};
        vecs[13] = '{1'b0, 1'b1, 32'hC0, 64'h20, 1'b1, 1'b1, 1'b1, 3'd1, 32'hC0, 64'h20};

        arst_n = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        f3 = 1'b0; v3 = 1'b0; i3 = '0; p3 = '0; or3 = 1'b0;
        #12;
        arst_n = 1'b1;
        #1;
        chk_state("reset", 1'b0, 1'b1, 3'd0, 32'h0, 64'h0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].flush, vecs[i].in_valid, vecs[i].instr, vecs[i].pc, vecs[i].out_ready);
            step();
            chk_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ready,
                      vecs[i].exp_count, vecs[i].exp_instr, vecs[i].exp_pc);
        end

        // Streaming: simultaneous push and pop with two entries resident.
        q = {{32'hC0, 64'h20}};
        drive(1'b0, 1'b1, 32'hD0, 64'h30, 1'b0);
        step();
        q.push_back({32'hD0, 64'h30});
        chk("stream prefill count", 64'(count), 64'd2);
        for (int i = 0; i < 10; i++) begin
            logic [XLEN-1:0] pc;
            pc = 64'h1000 + 64'(4 * i);
            drive(1'b0, 1'b1, pc[31:0] ^ 32'h13, pc, 1'b1);
            #1;
            chk($sformatf("stream%0d head", i), {out_instr, out_pc[31:0]},
                {q[0][95:64], q[0][31:0]});
            step();
            void'(q.pop_front());
            q.push_back({pc[31:0] ^ 32'h13, pc});
            chk($sformatf("stream%0d count", i), 64'(count), 64'd2);
        end

        // Flush with three entries and a concurrent push that must be discarded.
        drive(1'b0, 1'b1, 32'hE0, 64'h40, 1'b0);
        step();
        chk("preflush count", 64'(count), 64'd3);
        drive(1'b1, 1'b1, 32'hBAD, 64'hBAD, 1'b1);
        #1;
        chk("flush cycle out_valid", 64'(out_valid), 64'd1);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        chk_state("post flush", 1'b0, 1'b1, 3'd0, 32'h0, 64'h0);
        drive(1'b0, 1'b1, 32'h2000, 64'h2000, 1'b0);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        chk_state("after flush push", 1'b1, 1'b1, 3'd1, 32'h2000, 64'h2000);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        step();
        chk("after flush drain", 64'(count), 64'd0);

        // Asynchronous reset mid-stream with two entries resident.
        drive(1'b0, 1'b1, 32'h3000, 64'h3000, 1'b0);
        step();
        drive(1'b0, 1'b1, 32'h3004, 64'h3004, 1'b0);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        chk("prereset count", 64'(count), 64'd2);
        #2;
        arst_n = 1'b0;
        #1;
        chk_state("async reset", 1'b0, 1'b1, 3'd0, 32'h0, 64'h0);
        step();
        arst_n = 1'b1;
        drive(1'b0, 1'b1, 32'h33, 64'h100, 1'b0);
        step();
        drive(1'b0, 1'b1, 32'h37, 64'h104, 1'b0);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        chk_state("post reset head", 1'b1, 1'b1, 3'd2, 32'h33, 64'h100);
        step();
        chk_state("post reset second", 1'b1, 1'b1, 3'd1, 32'h37, 64'h104);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b0);

        // DEPTH=3 instance: biased random traffic with one flush, checked against a queue model.
        for (int c = 0; c < 90; c++) begin
            logic mpush, mpop;
            logic [XLEN-1:0] exp_pc;
            f3  = (c == 45);
            v3  = ($urandom_range(0, 3) != 0);
            or3 = ($urandom_range(0, 2) != 0);
            p3  = 64'h5000 + 64'(4 * c);
            i3  = 32'(c) ^ 32'h13;
            #1;
            exp_pc = (m3.size() != 0) ? m3[0][63:0] : 64'h0;
            chk($sformatf("d3 c%0d flags", c), {61'h0, ov3, rdy3, 1'b0} | 64'(cnt3) << 3,
                {61'h0, m3.size() != 0, m3.size() != 3, 1'b0} | 64'(m3.size()) << 3);
            chk($sformatf("d3 c%0d head", c), op3 ^ 64'(oi3),
                (m3.size() != 0) ? exp_pc ^ 64'(m3[0][95:64]) : 64'h0);
            mpush = v3 && (m3.size() != 3);
            mpop  = or3 && (m3.size() != 0);
            step();
            if (f3) begin
                m3.delete();
            end else begin
                if (mpop) void'(m3.pop_front());
                if (mpush) m3.push_back({i3, p3});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
